// File: rtl/ccip_if_pkg.sv
// Subset of the CCI-P interface types used by the MMIO CSR bridge.
package ccip_if_pkg;
  typedef logic [15:0]  t_ccip_mmioAddr;
  typedef logic [8:0]   t_ccip_tid;
  typedef logic [511:0] t_ccip_clData;
  typedef logic [63:0]  t_ccip_mmioData;

  typedef struct packed {
    logic [1:0]  vc_used;
    logic        rsvd1;
    logic        hit_miss;
    logic [1:0]  rsvd0;
    logic [1:0]  cl_num;
    logic [3:0]  resp_type;
    logic [15:0] mdata;
  } t_ccip_c0_RspMemHdr;

  typedef struct packed {
    t_ccip_mmioAddr address;
    logic [1:0]     length;
    logic           rsvd;
    t_ccip_tid      tid;
  } t_ccip_c0_ReqMmioHdr;

  typedef struct packed {
    t_ccip_tid tid;
  } t_ccip_c2_RspMmioHdr;

  typedef struct packed {
    t_ccip_c0_RspMemHdr hdr;
    t_ccip_clData       data;
    logic               rspValid;
    logic               mmioRdValid;
    logic               mmioWrValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    t_ccip_c2_RspMmioHdr hdr;
    logic                mmioRdValid;
    t_ccip_mmioData      data;
  } t_if_ccip_c2_Tx;
endpackage

// File: rtl/ccip_mmio_csr_bridge_pkg.sv
// Shared types for the MMIO-to-CSR bridge: read queue entry, read FSM states.
package ccip_csr_bridge_pkg;
  import ccip_if_pkg::*;

  localparam logic [63:0] TIMEOUT_DATA = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct packed {
    t_ccip_tid      tid;
    t_ccip_mmioAddr addr;
    logic [1:0]     len;
  } t_mmio_rd_entry;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} t_rd_state;

  // Only length 2'b00 is a 4B read; 64B lengths are answered as 8B.
  function automatic logic [63:0] rd_data_sel(t_mmio_rd_entry e, logic [63:0] d);
    if (e.len != 2'b00) return d;
    return e.addr[0] ? {32'h0, d[63:32]} : {32'h0, d[31:0]};
  endfunction
endpackage

// File: rtl/ccip_mmio_csr_bridge_if.sv
// AFU-side CSR bus: fire-and-forget writes, ready/valid reads with a data strobe.
interface ccip_mmio_csr_bridge_if;
  logic        csr_wr_valid;
  logic [15:0] csr_wr_addr;
  logic [63:0] csr_wr_data;
  logic        csr_wr_is8b;
  logic        csr_rd_valid;
  logic [15:0] csr_rd_addr;
  logic        csr_rd_ready;
  logic        csr_rd_rsp_valid;
  logic [63:0] csr_rd_rsp_data;

  modport master (
    output csr_wr_valid, csr_wr_addr, csr_wr_data, csr_wr_is8b,
    output csr_rd_valid, csr_rd_addr,
    input  csr_rd_ready, csr_rd_rsp_valid, csr_rd_rsp_data
  );
  modport slave (
    input  csr_wr_valid, csr_wr_addr, csr_wr_data, csr_wr_is8b,
    input  csr_rd_valid, csr_rd_addr,
    output csr_rd_ready, csr_rd_rsp_valid, csr_rd_rsp_data
  );
endinterface

// File: rtl/ccip_mmio_csr_bridge_rd_fifo.sv
// In-order queue of outstanding MMIO reads; a push into a full queue is
// accepted when the head is popped in the same cycle.
module ccip_mmio_rd_fifo
  import ccip_csr_bridge_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push_i,
  input  t_mmio_rd_entry din_i,
  input  logic           pop_i,
  output t_mmio_rd_entry head_o,
  output logic           full_o,
  output logic           empty_o
);
  localparam int AW = $clog2(DEPTH);

  t_mmio_rd_entry mem_q [DEPTH];
  logic [AW:0]    wp_q, rp_q;
  logic           wr_en, rd_en;

  assign empty_o = (wp_q == rp_q);
  assign full_o  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign wr_en   = push_i && (!full_o || pop_i);
  assign rd_en   = pop_i && !empty_o;
  assign head_o  = mem_q[rp_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (wr_en) wp_q <= wp_q + 1'b1;
      if (rd_en) rp_q <= rp_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wp_q[AW-1:0]] <= din_i;
  end
endmodule

// File: rtl/ccip_mmio_csr_bridge.sv
// CCI-P MMIO to AFU CSR bridge: registered c0 input, in-order read queue,
// read FSM with a WAIT timeout so the host always gets a c2 response.
module ccip_mmio_csr_bridge
  import ccip_if_pkg::*;
#(
  parameter int          RD_FIFO_DEPTH = 4,
  parameter int          RD_TIMEOUT    = 512,
  parameter logic [63:0] TIMEOUT_DATA  = ccip_csr_bridge_pkg::TIMEOUT_DATA
) (
  input  logic                           pClk,
  input  logic                           pck_cp2af_softReset,
  input  t_if_ccip_c0_Rx                 c0_rx,
  output t_if_ccip_c2_Tx                 c2_tx,
  ccip_mmio_csr_bridge_if.master         csr,
  output logic                           err_rd_overflow,
  output logic                           err_timeout,
  output logic                           err_bad_len
);
  import ccip_csr_bridge_pkg::t_mmio_rd_entry;
  import ccip_csr_bridge_pkg::t_rd_state;
  import ccip_csr_bridge_pkg::IDLE;
  import ccip_csr_bridge_pkg::ISSUE;
  import ccip_csr_bridge_pkg::WAIT;
  import ccip_csr_bridge_pkg::RESP;
  import ccip_csr_bridge_pkg::rd_data_sel;

  localparam int TW = $clog2(RD_TIMEOUT) + 1;

  t_ccip_c0_ReqMmioHdr req_hdr;
  assign req_hdr = t_ccip_c0_ReqMmioHdr'(c0_rx.hdr);

  logic unused_c0;
  assign unused_c0 = ^{c0_rx.data[511:64], c0_rx.rspValid, req_hdr.rsvd};

  // Input stage: write strobe and read push are both one cycle after c0
  logic           wr_vld_q, wr_is8b_q;
  t_ccip_mmioAddr wr_addr_q;
  logic [63:0]    wr_data_q;
  logic           push_q;
  t_mmio_rd_entry push_ent_q;
  logic           err_bad_len_q, err_ovf_q;

  t_mmio_rd_entry head;
  logic           full, empty, pop;

  always_ff @(posedge pClk or posedge pck_cp2af_softReset) begin
    if (pck_cp2af_softReset) begin
      wr_vld_q      <= 1'b0;
      wr_is8b_q     <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      push_q        <= 1'b0;
      push_ent_q    <= '0;
      err_bad_len_q <= 1'b0;
      err_ovf_q     <= 1'b0;
    end else begin
      wr_vld_q <= c0_rx.mmioWrValid && !req_hdr.length[1];
      if (c0_rx.mmioWrValid) begin
        wr_addr_q <= req_hdr.address;
        wr_data_q <= c0_rx.data[63:0];
        wr_is8b_q <= req_hdr.length[0];
      end
      push_q <= c0_rx.mmioRdValid;
      if (c0_rx.mmioRdValid)
        push_ent_q <= '{tid: req_hdr.tid, addr: req_hdr.address, len: req_hdr.length};
      if ((c0_rx.mmioRdValid || c0_rx.mmioWrValid) && req_hdr.length[1])
        err_bad_len_q <= 1'b1;
      if (push_q && full && !pop)
        err_ovf_q <= 1'b1;
    end
  end

  ccip_mmio_rd_fifo #(.DEPTH(RD_FIFO_DEPTH)) u_rd_fifo (
    .clk     (pClk),
    .rst     (pck_cp2af_softReset),
    .push_i  (push_q),
    .din_i   (push_ent_q),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  t_rd_state      state_q;
  t_mmio_rd_entry cur_q;
  logic           rd_vld_q;
  logic [TW-1:0]  timer_q;
  logic           c2_vld_q;
  t_ccip_tid      c2_tid_q;
  logic [63:0]    c2_data_q;
  logic           err_to_q;

  // Head stays queued until its response goes out, so DEPTH counts the in-flight read
  assign pop = (state_q == RESP);

  always_ff @(posedge pClk or posedge pck_cp2af_softReset) begin
    if (pck_cp2af_softReset) begin
      state_q   <= IDLE;
      cur_q     <= '0;
      rd_vld_q  <= 1'b0;
      timer_q   <= '0;
      c2_vld_q  <= 1'b0;
      c2_tid_q  <= '0;
      c2_data_q <= '0;
      err_to_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (!empty) begin
          cur_q    <= head;
          rd_vld_q <= 1'b1;
          state_q  <= ISSUE;
        end
        ISSUE: if (csr.csr_rd_ready) begin
          rd_vld_q <= 1'b0;
          timer_q  <= '0;
          state_q  <= WAIT;
        end
        WAIT: begin
          if (csr.csr_rd_rsp_valid) begin
            c2_vld_q  <= 1'b1;
            c2_tid_q  <= cur_q.tid;
            c2_data_q <= rd_data_sel(cur_q, csr.csr_rd_rsp_data);
            state_q   <= RESP;
          end else if (timer_q == TW'(RD_TIMEOUT - 1)) begin
            c2_vld_q  <= 1'b1;
            c2_tid_q  <= cur_q.tid;
            c2_data_q <= TIMEOUT_DATA;
            err_to_q  <= 1'b1;
            state_q   <= RESP;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        RESP: begin
          c2_vld_q  <= 1'b0;
          c2_tid_q  <= '0;
          c2_data_q <= '0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign c2_tx = '{hdr: '{tid: c2_tid_q}, mmioRdValid: c2_vld_q, data: c2_data_q};

  assign csr.csr_wr_valid = wr_vld_q;
  assign csr.csr_wr_addr  = wr_addr_q;
  assign csr.csr_wr_data  = wr_data_q;
  assign csr.csr_wr_is8b  = wr_is8b_q;
  assign csr.csr_rd_valid = rd_vld_q;
  assign csr.csr_rd_addr  = {cur_q.addr[15:1], 1'b0};

  assign err_rd_overflow = err_ovf_q;
  assign err_timeout     = err_to_q;
  assign err_bad_len     = err_bad_len_q;
endmodule

// File: tb/tb_ccip_mmio_csr_bridge.sv
// Directed bench for the MMIO CSR bridge with a small CSR read responder.
module tb_ccip_mmio_csr_bridge;
  import ccip_if_pkg::*;

  logic           pClk = 1'b0;
  logic           rst;
  t_if_ccip_c0_Rx c0_rx;
  t_if_ccip_c2_Tx c2_tx;
  logic           err_rd_overflow, err_timeout, err_bad_len;
  int             total = 0;
  int             bad = 0;
  logic [8:0]     got_tid[$];
  logic [63:0]    got_data[$];

  ccip_mmio_csr_bridge_if csr_if();

  ccip_mmio_csr_bridge dut (
    .pClk                (pClk),
    .pck_cp2af_softReset (rst),
    .c0_rx               (c0_rx),
    .c2_tx               (c2_tx),
    .csr                 (csr_if),
    .err_rd_overflow     (err_rd_overflow),
    .err_timeout         (err_timeout),
    .err_bad_len         (err_bad_len)
  );

  always #5 pClk = ~pClk;

  task automatic tick();
    @(posedge pClk);
    #1;
  endtask

  // Presents one MMIO request for a single cycle; returns one cycle later.
  task automatic send_mmio(input logic is_rd, input logic [15:0] addr, input logic [1:0] len,
                           input logic [8:0] tid, input logic [63:0] data);
    t_ccip_c0_ReqMmioHdr mh;
    mh = '{address: addr, length: len, rsvd: 1'b0, tid: tid};
    c0_rx.hdr         = t_ccip_c0_RspMemHdr'(mh);
    c0_rx.data        = {{14{32'hDEAD_BEEF}}, data};
    c0_rx.mmioRdValid = is_rd;
    c0_rx.mmioWrValid = !is_rd;
    tick();
    c0_rx = '0;
  endtask

  // CSR side: accepts reads, answers lat cycles later with data tagged by address.
  task automatic run_rsp(input int lat, input int budget, input int max_rsp);
    int          cd;
    logic [15:0] a;
    cd = 0;
    a  = '0;
    csr_if.csr_rd_ready = 1'b1;
    for (int c = 0; c < budget && got_tid.size() < max_rsp; c++) begin
      csr_if.csr_rd_rsp_valid = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          csr_if.csr_rd_rsp_valid = 1'b1;
          csr_if.csr_rd_rsp_data  = {48'h5A5A_0000_C0DE, a};
        end
      end
      if (csr_if.csr_rd_valid && csr_if.csr_rd_ready) begin
        cd = lat;
        a  = csr_if.csr_rd_addr;
      end
      tick();
      if (c2_tx.mmioRdValid) begin
        got_tid.push_back(c2_tx.hdr.tid);
        got_data.push_back(c2_tx.data);
      end
    end
    csr_if.csr_rd_rsp_valid = 1'b0;
    csr_if.csr_rd_ready     = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    c0_rx = '0;
    csr_if.csr_rd_ready = 1'b0;
    csr_if.csr_rd_rsp_valid = 1'b0;
    csr_if.csr_rd_rsp_data = '0;
    repeat (3) tick();
    total++; if (c2_tx !== '0) begin bad++; $display("FAIL reset_c2: got %h want 0", c2_tx); end
    total++; if ({csr_if.csr_wr_valid, csr_if.csr_rd_valid} !== 2'b00) begin bad++; $display("FAIL reset_csr_valid: got %b want 00", {csr_if.csr_wr_valid, csr_if.csr_rd_valid}); end
    total++; if ({err_rd_overflow, err_timeout, err_bad_len} !== 3'b000) begin bad++; $display("FAIL reset_err: got %b want 000", {err_rd_overflow, err_timeout, err_bad_len}); end
    rst = 1'b0;
    repeat (2) tick();
    total++; if (csr_if.csr_rd_valid !== 1'b0) begin bad++; $display("FAIL reset_idle_rd: got %b want 0", csr_if.csr_rd_valid); end
  endtask

  task automatic test_write();
    send_mmio(1'b0, 16'h0010, 2'b01, 9'h0, 64'h1122_3344_5566_7788);
    total++; if (csr_if.csr_wr_valid !== 1'b1) begin bad++; $display("FAIL wr8_valid: got %b want 1", csr_if.csr_wr_valid); end
    total++; if (csr_if.csr_wr_addr !== 16'h0010) begin bad++; $display("FAIL wr8_addr: got %h want 0010", csr_if.csr_wr_addr); end
    total++; if (csr_if.csr_wr_data !== 64'h1122_3344_5566_7788) begin bad++; $display("FAIL wr8_data: got %h want 1122334455667788", csr_if.csr_wr_data); end
    total++; if (csr_if.csr_wr_is8b !== 1'b1) begin bad++; $display("FAIL wr8_is8b: got %b want 1", csr_if.csr_wr_is8b); end
    tick();
    total++; if (csr_if.csr_wr_valid !== 1'b0) begin bad++; $display("FAIL wr8_one_cycle: got %b want 0", csr_if.csr_wr_valid); end
    send_mmio(1'b0, 16'h0021, 2'b00, 9'h0, 64'h9999_8888_7777_6666);
    total++; if ({csr_if.csr_wr_valid, csr_if.csr_wr_is8b} !== 2'b10) begin bad++; $display("FAIL wr4_valid_is8b: got %b want 10", {csr_if.csr_wr_valid, csr_if.csr_wr_is8b}); end
    total++; if (csr_if.csr_wr_addr !== 16'h0021) begin bad++; $display("FAIL wr4_addr: got %h want 0021", csr_if.csr_wr_addr); end
    tick();
  endtask

  task automatic test_read_4b();
    send_mmio(1'b1, 16'h0013, 2'b00, 9'h005, 64'h0);
    tick();
    total++; if (csr_if.csr_rd_valid !== 1'b0) begin bad++; $display("FAIL rd_early_valid: got %b want 0", csr_if.csr_rd_valid); end
    tick();
    total++; if (csr_if.csr_rd_valid !== 1'b1) begin bad++; $display("FAIL rd_latency_n3: got %b want 1", csr_if.csr_rd_valid); end
    total++; if (csr_if.csr_rd_addr !== 16'h0012) begin bad++; $display("FAIL rd_addr: got %h want 0012", csr_if.csr_rd_addr); end
    csr_if.csr_rd_ready = 1'b1;
    tick();
    csr_if.csr_rd_ready = 1'b0;
    csr_if.csr_rd_rsp_valid = 1'b1;
    csr_if.csr_rd_rsp_data = 64'hAAAA_BBBB_CCCC_DDDD;
    tick();
    csr_if.csr_rd_rsp_valid = 1'b0;
    total++; if (c2_tx.mmioRdValid !== 1'b1) begin bad++; $display("FAIL rd4_c2_valid_m1: got %b want 1", c2_tx.mmioRdValid); end
    total++; if (c2_tx.hdr.tid !== 9'h005) begin bad++; $display("FAIL rd4_tid: got %h want 005", c2_tx.hdr.tid); end
    total++; if (c2_tx.data !== 64'h0000_0000_AAAA_BBBB) begin bad++; $display("FAIL rd4_data: got %h want 00000000aaaabbbb", c2_tx.data); end
    tick();
    total++; if ({c2_tx.mmioRdValid, c2_tx.data} !== 65'h0) begin bad++; $display("FAIL rd4_c2_clear: got %h want 0", {c2_tx.mmioRdValid, c2_tx.data}); end
  endtask

  task automatic test_back_to_back();
    got_tid.delete(); got_data.delete();
    for (int k = 1; k <= 4; k++) send_mmio(1'b1, 16'(16'h0100 + 2 * k), 2'b01, 9'(k), 64'h0);
    run_rsp(3, 200, 4);
    total++; if (got_tid.size() !== 4) begin bad++; $display("FAIL b2b_count: got %0d want 4", got_tid.size()); end
    for (int k = 1; k <= 4 && k <= got_tid.size(); k++) begin
      total++; if (got_tid[k-1] !== 9'(k)) begin bad++; $display("FAIL b2b_tid%0d: got %h want %h", k, got_tid[k-1], 9'(k)); end
      total++; if (got_data[k-1] !== {48'h5A5A_0000_C0DE, 16'(16'h0100 + 2 * k)}) begin bad++; $display("FAIL b2b_data%0d: got %h want %h", k, got_data[k-1], {48'h5A5A_0000_C0DE, 16'(16'h0100 + 2 * k)}); end
    end
    total++; if ({err_rd_overflow, err_timeout, err_bad_len} !== 3'b000) begin bad++; $display("FAIL b2b_err: got %b want 000", {err_rd_overflow, err_timeout, err_bad_len}); end
  endtask

  task automatic test_timeout();
    int cnt;
    int seen;
    send_mmio(1'b1, 16'h0020, 2'b01, 9'h007, 64'h0);
    csr_if.csr_rd_ready = 1'b1;
    for (int w = 0; w < 10 && !csr_if.csr_rd_valid; w++) tick();
    total++; if (csr_if.csr_rd_valid !== 1'b1) begin bad++; $display("FAIL to_issue: got %b want 1", csr_if.csr_rd_valid); end
    tick();
    csr_if.csr_rd_ready = 1'b0;
    cnt = 0;
    while (!c2_tx.mmioRdValid && cnt < 600) begin tick(); cnt++; end
    total++; if (cnt !== 512) begin bad++; $display("FAIL to_latency: got %0d want 512", cnt); end
    total++; if (c2_tx.data !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL to_data: got %h want ffffffffffffffff", c2_tx.data); end
    total++; if (c2_tx.hdr.tid !== 9'h007) begin bad++; $display("FAIL to_tid: got %h want 007", c2_tx.hdr.tid); end
    total++; if (err_timeout !== 1'b1) begin bad++; $display("FAIL to_err: got %b want 1", err_timeout); end
    tick();
    csr_if.csr_rd_rsp_valid = 1'b1;
    csr_if.csr_rd_rsp_data = 64'h1234_5678_9ABC_DEF0;
    tick();
    csr_if.csr_rd_rsp_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin if (c2_tx.mmioRdValid) seen++; tick(); end
    total++; if (seen !== 0) begin bad++; $display("FAIL to_late_rsp: got %0d responses want 0", seen); end
  endtask

  task automatic test_overflow();
    got_tid.delete(); got_data.delete();
    for (int k = 0; k < 5; k++) send_mmio(1'b1, 16'(16'h0200 + 2 * k), 2'b01, 9'(9'h011 + k), 64'h0);
    repeat (2) tick();
    total++; if (err_rd_overflow !== 1'b1) begin bad++; $display("FAIL ovf_err: got %b want 1", err_rd_overflow); end
    run_rsp(1, 100, 8);
    total++; if (got_tid.size() !== 4) begin bad++; $display("FAIL ovf_count: got %0d want 4", got_tid.size()); end
    for (int k = 0; k < 4 && k < got_tid.size(); k++) begin
      total++; if (got_tid[k] !== 9'(9'h011 + k)) begin bad++; $display("FAIL ovf_tid%0d: got %h want %h", k, got_tid[k], 9'(9'h011 + k)); end
    end
  endtask

  task automatic test_reset_mid();
    got_tid.delete(); got_data.delete();
    send_mmio(1'b1, 16'h0300, 2'b01, 9'h021, 64'h0);
    send_mmio(1'b1, 16'h0302, 2'b01, 9'h022, 64'h0);
    repeat (4) tick();
    rst = 1'b1;
    #2;
    total++; if ({err_rd_overflow, err_timeout, err_bad_len} !== 3'b000) begin bad++; $display("FAIL rstmid_err: got %b want 000", {err_rd_overflow, err_timeout, err_bad_len}); end
    total++; if ({c2_tx.mmioRdValid, csr_if.csr_rd_valid} !== 2'b00) begin bad++; $display("FAIL rstmid_valid: got %b want 00", {c2_tx.mmioRdValid, csr_if.csr_rd_valid}); end
    tick();
    rst = 1'b0;
    run_rsp(1, 20, 8);
    total++; if (got_tid.size() !== 0) begin bad++; $display("FAIL rstmid_dropped: got %0d responses want 0", got_tid.size()); end
    send_mmio(1'b1, 16'h0040, 2'b00, 9'h033, 64'h0);
    run_rsp(1, 40, 1);
    total++; if (got_tid.size() !== 1) begin bad++; $display("FAIL rstmid_after_count: got %0d want 1", got_tid.size()); end
    if (got_tid.size() == 1) begin
      total++; if (got_tid[0] !== 9'h033) begin bad++; $display("FAIL rstmid_after_tid: got %h want 033", got_tid[0]); end
      total++; if (got_data[0] !== 64'h0000_0000_C0DE_0040) begin bad++; $display("FAIL rstmid_after_data: got %h want 00000000c0de0040", got_data[0]); end
    end
  endtask

  task automatic test_bad_len();
    got_tid.delete(); got_data.delete();
    repeat (2) tick();
    send_mmio(1'b0, 16'h0044, 2'b10, 9'h0, 64'h5555_6666_7777_8888);
    total++; if (csr_if.csr_wr_valid !== 1'b0) begin bad++; $display("FAIL badlen_no_strobe: got %b want 0", csr_if.csr_wr_valid); end
    total++; if (err_bad_len !== 1'b1) begin bad++; $display("FAIL badlen_err: got %b want 1", err_bad_len); end
    send_mmio(1'b1, 16'h0051, 2'b11, 9'h02A, 64'h0);
    run_rsp(1, 40, 1);
    total++; if (got_tid.size() !== 1) begin bad++; $display("FAIL badlen_rd_count: got %0d want 1", got_tid.size()); end
    if (got_tid.size() == 1) begin
      total++; if (got_data[0] !== 64'h5A5A_0000_C0DE_0050) begin bad++; $display("FAIL badlen_rd_data: got %h want 5a5a0000c0de0050", got_data[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_4b();
    test_back_to_back();
    test_timeout();
    test_overflow();
    test_reset_mid();
    test_bad_len();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
